// File: rtl/window_buffer_3x3.sv
// Streaming 3x3 window generator: two line buffers plus a 3x3 shift window,
// emitting one window per interior pixel over a valid/ready handshake.
module window_buffer_3x3 #(
  parameter int P_SUBPIXEL_DEPTH = 8,
  parameter int P_IMAGE_WIDTH    = 640,
  parameter int P_IMAGE_HEIGHT   = 480
) (
  input  logic                          I_CLK,
  input  logic                          I_RESET_N,
  input  logic [P_SUBPIXEL_DEPTH-1:0]   I_PIXEL,
  input  logic                          I_VALID,
  output logic                          O_READY,
  output logic [9*P_SUBPIXEL_DEPTH-1:0] O_WINDOW,
  output logic                          O_VALID,
  input  logic                          I_READY,
  output logic                          O_FRAME_DONE
);

  localparam int P_COL_WIDTH = $clog2(P_IMAGE_WIDTH);
  localparam int P_ROW_WIDTH = $clog2(P_IMAGE_HEIGHT);

  localparam logic [P_COL_WIDTH-1:0] LP_COL_LAST = P_COL_WIDTH'(P_IMAGE_WIDTH - 1);
  localparam logic [P_ROW_WIDTH-1:0] LP_ROW_LAST = P_ROW_WIDTH'(P_IMAGE_HEIGHT - 1);
  localparam logic [P_COL_WIDTH-1:0] LP_COL_TWO  = P_COL_WIDTH'(2);
  localparam logic [P_ROW_WIDTH-1:0] LP_ROW_TWO  = P_ROW_WIDTH'(2);

  typedef logic [P_SUBPIXEL_DEPTH-1:0] pixel_t;

  pixel_t lb0_q [P_IMAGE_WIDTH];
  pixel_t lb1_q [P_IMAGE_WIDTH];

  pixel_t win_q [9];
  pixel_t win_d [9];

  logic [P_COL_WIDTH-1:0] col_q, col_d;
  logic [P_ROW_WIDTH-1:0] row_q, row_d;
  logic                   valid_q, valid_d;
  logic                   frame_done_q, frame_done_d;
  logic                   accept;
  logic                   col_last;
  logic                   row_last;

  assign O_READY      = !valid_q || I_READY;
  assign accept       = I_VALID && O_READY;
  assign col_last     = (col_q == LP_COL_LAST);
  assign row_last     = (row_q == LP_ROW_LAST);
  assign O_VALID      = valid_q;
  assign O_FRAME_DONE = frame_done_q;
  assign O_WINDOW     = {win_q[0], win_q[1], win_q[2],
                         win_q[3], win_q[4], win_q[5],
                         win_q[6], win_q[7], win_q[8]};

  always_comb begin
    col_d        = col_q;
    row_d        = row_q;
    win_d        = win_q;
    valid_d      = I_READY ? 1'b0 : valid_q;
    frame_done_d = 1'b0;
    if (accept) begin
      // Each row shifts left; the new column {lb1, lb0, pixel} enters on the right.
      win_d[0] = win_q[1];
      win_d[1] = win_q[2];
      win_d[2] = lb1_q[col_q];
      win_d[3] = win_q[4];
      win_d[4] = win_q[5];
      win_d[5] = lb0_q[col_q];
      win_d[6] = win_q[7];
      win_d[7] = win_q[8];
      win_d[8] = I_PIXEL;
      valid_d      = (row_q >= LP_ROW_TWO) && (col_q >= LP_COL_TWO);
      frame_done_d = row_last && col_last;
      if (col_last) begin
        col_d = '0;
        row_d = row_last ? '0 : row_q + 1'b1;
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge I_CLK or negedge I_RESET_N) begin
    if (!I_RESET_N) begin
      col_q        <= '0;
      row_q        <= '0;
      win_q        <= '{default: '0};
      valid_q      <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      col_q        <= col_d;
      row_q        <= row_d;
      win_q        <= win_d;
      valid_q      <= valid_d;
      frame_done_q <= frame_done_d;
    end
  end

  // Line buffers carry no reset; stale rows are never emitted because of the row >= 2 gate.
  always_ff @(posedge I_CLK) begin
    if (accept) begin
      lb1_q[col_q] <= lb0_q[col_q];
      lb0_q[col_q] <= I_PIXEL;
    end
  end

endmodule

// File: doc/window_buffer_3x3.md
Name: window_buffer_3x3

Overview:
Streaming 3x3 neighbourhood generator that sits directly downstream of the grayscale stage. It accepts one grayscale pixel per handshake in raster order and stores the two previous image rows in line buffers. For every interior pixel it emits a 9-pixel window to the edge-detection (Sobel) stage, using a valid/ready handshake on both sides.

Parameters:
P_SUBPIXEL_DEPTH, 8, bit width of one grayscale pixel
P_IMAGE_WIDTH, 640, pixels per row (>= 3)
P_IMAGE_HEIGHT, 480, rows per frame (>= 3)
P_COL_WIDTH, $clog2(P_IMAGE_WIDTH), local: column counter width
P_ROW_WIDTH, $clog2(P_IMAGE_HEIGHT), local: row counter width

Ports:
I_CLK  input  1  clock, rising edge
I_RESET_N  input  1  asynchronous active-low reset
I_PIXEL  input  P_SUBPIXEL_DEPTH  grayscale pixel from upstream
I_VALID  input  1  I_PIXEL valid
O_READY  output  1  block can accept I_PIXEL this cycle
O_WINDOW  output  9*P_SUBPIXEL_DEPTH  3x3 window, raster order, top-left in MSBs, current pixel in LSBs
O_VALID  output  1  O_WINDOW valid
I_READY  input  1  downstream accepts O_WINDOW
O_FRAME_DONE  output  1  one-cycle pulse after the last pixel of a frame is accepted

Behaviour:
- Reset: I_CLK only clock; I_RESET_N low clears state immediately, regardless of clock.
  - Col/row counters = 0; window registers = 0 (O_WINDOW = 0); O_VALID = 0; O_FRAME_DONE = 0.
  - Line-buffer contents are not reset and undefined after reset.
  - O_READY = 1 after reset.
  - Reset mid-frame abandons the frame; the next accepted pixel is (row 0, col 0).
- Accept: accept = I_VALID && O_READY. O_READY = !O_VALID || I_READY (combinational).
- On accept at (row r, col c):
  - New column = {lb1[c], lb0[c], I_PIXEL}, top to bottom.
  - Each window row shifts left one position; the new column enters the right-hand position.
  - lb1[c] <= lb0[c]; lb0[c] <= I_PIXEL.
  - Col increments. At P_IMAGE_WIDTH-1, col wraps to 0 and row increments.
  - At (P_IMAGE_HEIGHT-1, P_IMAGE_WIDTH-1), row and col both wrap to 0.
- Output:
  - O_VALID is registered. On accept it becomes (r >= 2 && c >= 2).
  - Without accept, O_VALID is cleared when I_READY = 1; otherwise it holds.
  - Latency: 1 cycle from accept to O_VALID/O_WINDOW.
  - Throughput: 1 window/cycle when I_VALID and I_READY are held high.
  - Windows per frame = (W-2)*(H-2). No window ever straddles rows or frames.
- O_WINDOW packing, row-major, each field P_SUBPIXEL_DEPTH wide, from MSB to LSB:
  - p(r-2,c-2), p(r-2,c-1), p(r-2,c)
  - p(r-1,c-2), p(r-1,c-1), p(r-1,c)
  - p(r,c-2), p(r,c-1), p(r,c)
- O_WINDOW may change while O_VALID = 0; it is meaningful only when O_VALID = 1.
- Backpressure: while O_VALID && !I_READY:
  - O_READY = 0.
  - Counters, line buffers, window and O_VALID hold.
  - O_WINDOW is bit-stable.
- Simultaneous events:
  - O_VALID && I_READY && I_VALID: the old window is consumed and the new pixel accepted in the same cycle; no bubble.
  - I_VALID = 0: no state change except O_VALID clearing on I_READY.
- O_FRAME_DONE:
  - Registered; 1 for exactly one cycle following acceptance of pixel (H-1, W-1), coincident with that pixel's O_VALID.
  - It is not held by backpressure.
- Frame wrap: line buffers are not cleared. Stale data is never emitted because windows are gated by r >= 2.
- Arithmetic: none on pixel data; pixels pass through unmodified.

Test Plan:
1. W=4, H=4, I_READY=1, stream pixels value 16*r+c -> first O_VALID one cycle after accepting pixel (2,2), O_WINDOW = 00,01,02,10,11,12,20,21,22 (hex); exactly 4 windows; the last is 11,12,13,21,22,23,31,32,33.
2. Same stream, I_VALID and I_READY held high -> windows for pixels (2,2),(2,3) on consecutive cycles, no row-boundary window at (3,0)/(3,1), O_FRAME_DONE pulses once, coincident with window 4.
3. Backpressure: drop I_READY for 5 cycles while O_VALID=1 -> O_READY=0, O_WINDOW unchanged, no pixels lost; on release the next window follows with correct contents.
4. Two back-to-back frames, second frame values 0x80+16*r+c -> first window of frame 2 is 80,81,82,90,91,92,A0,A1,A2; no frame-1 data appears.
5. Assert I_RESET_N low asynchronously after 7 pixels (mid-clock) -> O_VALID, O_FRAME_DONE and O_WINDOW go 0 immediately; after release, a full 16-pixel frame yields exactly 4 correct windows.
6. Random I_VALID/I_READY toggling over 3 frames with W=5, H=4 -> 6 windows per frame, all matching a reference model, O_WINDOW stable whenever O_VALID && !I_READY.
